// File: rtl/match_capture_buffer_if.sv
// match_capture_buffer_if: comparator word stream in, committed packet stream out
interface match_capture_buffer_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        eop;
  logic        match;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  modport master (
    output data_in, data_valid, eop, match, out_ready,
    input  out_data, out_valid, out_last
  );
  modport slave (
    input  data_in, data_valid, eop, match, out_ready,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/match_capture_buffer.sv
// match_capture_buffer: packet FIFO that stores whole matched frames and exposes only committed ones
module match_capture_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 7
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  match_capture_buffer_if.slave bus,
  output logic [CNT_W-1:0]     pkt_count,
  output logic                 overflow,
  output logic [7:0]           drop_count,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;
  state_t            state, state_nxt;
  logic [32:0]       mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, commit_ptr, rd_ptr, used;
  logic              full, take, wr, ovf, commit, pop, head_last;
  // Full is judged on the pre-pop read pointer, so a same-cycle pop never rescues a write.
  assign used           = wr_ptr - rd_ptr;
  assign full           = used == (ADDR_W+1)'(DEPTH);
  assign bus.out_valid  = rd_ptr != commit_ptr;
  assign head_last      = mem[rd_ptr[ADDR_W-1:0]][32];
  assign bus.out_data   = bus.out_valid ? mem[rd_ptr[ADDR_W-1:0]][31:0] : 32'd0;
  assign bus.out_last   = bus.out_valid & head_last;
  assign pop            = bus.out_valid & bus.out_ready;
  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end
  // Next state: clear wins, then any accepted-or-overflowing word, then DROP waits for eop
  always_comb begin
    state_nxt = state;
    if (clear) state_nxt = IDLE;
    else if (take) state_nxt = bus.eop ? IDLE : (full ? DROP : CAPTURE);
    else if (state == DROP && bus.data_valid && bus.eop) state_nxt = IDLE;
  end
  // Per-cycle write decisions derived from state and inputs
  always_comb begin
    take   = !clear & bus.data_valid & ((state == CAPTURE) | ((state == IDLE) & bus.match));
    wr     = take & !full;
    ovf    = take & full;
    commit = wr & bus.eop;
    busy   = state == CAPTURE;
  end
  // Storage write; the last flag travels with each word
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[ADDR_W-1:0]] <= {bus.eop, bus.data_in};
  end
  // Pointers, packet accounting and drop statistics
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      overflow <= ovf;
      if (clear || ovf) wr_ptr <= commit_ptr;
      else if (wr) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (commit) commit_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      if (commit != (pop & head_last))
        pkt_count <= commit ? pkt_count + CNT_W'(1) : pkt_count - CNT_W'(1);
      if (ovf && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_match_capture_buffer.sv
// tb_match_capture_buffer: randomized scoreboard bench against a frame-level reference model
module tb_match_capture_buffer;
  localparam int DEPTH = 8, ADDR_W = 3, CNT_W = 4;
  logic clk = 1'b0, n_rst = 1'b0, clear = 1'b0;
  logic [CNT_W-1:0] pkt_count;
  logic overflow, busy;
  logic [7:0] drop_count;
  match_capture_buffer_if ifc();
  match_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .bus(ifc),
    .pkt_count(pkt_count), .overflow(overflow), .drop_count(drop_count), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [32:0] mq[$], exp_q[$], pend[$];
  bit capturing, dropping, exp_ovf, rdy;
  int drops;
  task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int lasts();
    int n = 0;
    foreach (mq[i]) n += int'(mq[i][32]);
    return n;
  endfunction
  // Scoreboard monitor: the head word must match the oldest expected committed word
  always @(negedge clk) begin
    if (n_rst) begin
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h expected=none at %0t", ifc.out_data, $time);
        end else begin
          chk("head_data", {1'b0, ifc.out_data}, {1'b0, exp_q[0][31:0]});
          chk("head_last", {32'd0, ifc.out_last}, {32'd0, exp_q[0][32]});
          if (ifc.out_ready) exp_q.delete(0);
        end
      end else chk("idle_out", {ifc.out_last, ifc.out_data}, 33'd0);
    end
  end
  task automatic model_reset();
    mq.delete(); exp_q.delete(); pend.delete();
    capturing = 0; dropping = 0; exp_ovf = 0; drops = 0;
  endtask
  task automatic step(bit dv, bit e, bit m, logic [31:0] d, bit c);
    bit pop = mq.size() > 0 && rdy;
    int occ = mq.size() + pend.size();
    bit cm = 0;
    exp_ovf = 0;
    if (c) begin
      pend.delete(); capturing = 0; dropping = 0;
    end else if (dropping) dropping = !(dv && e);
    else if (dv && (capturing || m)) begin
      if (occ == DEPTH) begin
        exp_ovf = 1;
        if (drops < 255) drops++;
        pend.delete(); capturing = 0; dropping = !e;
      end else begin
        pend.push_back({e, d});
        capturing = !e;
        cm = e;
      end
    end
    if (pop) mq.delete(0);
    if (cm) begin
      foreach (pend[i]) begin mq.push_back(pend[i]); exp_q.push_back(pend[i]); end
      pend.delete();
    end
  endtask
  task automatic cyc(bit dv, bit e, bit m, logic [31:0] d, bit c);
    ifc.data_valid = dv; ifc.eop = e; ifc.match = m; ifc.data_in = d; clear = c; ifc.out_ready = rdy;
    step(dv, e, m, d, c);
    @(posedge clk); #1;
    chk("out_valid", {32'd0, ifc.out_valid}, {32'd0, mq.size() > 0});
    chk("pkt_count", {29'd0, pkt_count}, 33'(lasts()));
    chk("busy", {32'd0, busy}, {32'd0, capturing});
    chk("overflow", {32'd0, overflow}, {32'd0, exp_ovf});
    chk("drop_count", {25'd0, drop_count}, 33'(drops));
  endtask
  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 32'd0, 0);
  endtask
  task automatic frame(logic [31:0] w[$], bit m);
    foreach (w[i]) cyc(1, i == w.size() - 1, m && i == 0, w[i], 0);
  endtask
  task automatic chk_reset();
    chk("rst_out", {ifc.out_last, ifc.out_data}, 33'd0);
    chk("rst_valid", {32'd0, ifc.out_valid}, 33'd0);
    chk("rst_pkt", {29'd0, pkt_count}, 33'd0);
    chk("rst_stat", {23'd0, overflow, drop_count, busy}, 33'd0);
  endtask
  initial begin
    logic [31:0] w[$];
    ifc.data_valid = 0; ifc.eop = 0; ifc.match = 0; ifc.data_in = 0; ifc.out_ready = 0; rdy = 0;
    model_reset();
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    rdy = 1;
    frame('{32'hE5F60000, 32'h01B2C3D4, 32'h00000000}, 1);
    idle(5);
    frame('{32'h11111111, 32'h22222222, 32'h33333333}, 0);
    idle(2);
    rdy = 0;
    w.delete();
    for (int i = 0; i < DEPTH + 2; i++) w.push_back($urandom);
    frame(w, 1);
    frame('{32'hA1B2C3D4, 32'h00000001}, 1);
    idle(1);
    rdy = 1;
    idle(4);
    rdy = 0;
    cyc(1, 0, 1, 32'h0BADF00D, 0);
    cyc(1, 0, 0, 32'h0BADF00E, 0);
    cyc(0, 0, 0, 32'd0, 1);
    cyc(1, 1, 1, 32'hF6000000, 0);
    idle(1);
    rdy = 1;
    idle(3);
    for (int r = 0; r < 4; r++) begin
      rdy = 0;
      frame('{$urandom, $urandom, $urandom}, 1);
      frame('{$urandom, $urandom, $urandom}, 1);
      idle(1);
      rdy = 1;
      idle(8);
    end
    rdy = 0;
    frame('{32'hCAFE0001, 32'hCAFE0002}, 1);
    cyc(1, 0, 1, 32'hDEAD0001, 0);
    cyc(1, 0, 0, 32'hDEAD0002, 0);
    #2 n_rst = 0;
    #1 chk_reset();
    model_reset();
    ifc.data_valid = 0; ifc.eop = 0; ifc.match = 0; clear = 0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    rdy = 1;
    frame('{32'h5EED0001, 32'h5EED0002}, 1);
    idle(4);
    for (int f = 0; f < 300; f++) begin
      int len = $urandom_range(1, DEPTH + 3);
      bit m = $urandom_range(0, 3) != 0;
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          rdy = $urandom_range(0, 2) != 0;
          cyc(0, 0, 0, $urandom, $urandom_range(0, 29) == 0);
        end
        rdy = $urandom_range(0, 2) != 0;
        cyc(1, i == len - 1, (m && i == 0) || $urandom_range(0, 15) == 0, $urandom,
            $urandom_range(0, 29) == 0);
      end
    end
    rdy = 1;
    idle(DEPTH + 4);
    chk("drained", 33'(exp_q.size()), 33'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
